// File: rtl/ddr2_sdram_phy_alt_mem_phy_pll_phase_stepper.sv
// PLL dynamic phase-shift stepper for the DDR2 sequencer.
// Runs one phase step per request and tracks each clock's phase position.
module ddr2_sdram_phy_alt_mem_phy_pll_phase_stepper #(
  parameter int CLOCK_INDEX_WIDTH     = 3,
  parameter int PLL_STEPS_PER_CYCLE   = 64,
  parameter int COUNTER_SELECT_OFFSET = 2,
  parameter int SETUP_CYCLES          = 2,
  parameter int STEP_CYCLES           = 2,
  parameter int TIMEOUT_CYCLES        = 255
) (
  input  logic                         seq_clk,
  input  logic                         reset_seq,
  input  logic                         seq_pll_start_reconfig,
  input  logic [CLOCK_INDEX_WIDTH-1:0] seq_pll_select,
  input  logic                         seq_pll_inc_dec_n,
  output logic                         phs_shft_busy,
  input  logic                         pll_locked,
  input  logic                         pll_phasedone,
  output logic [CLOCK_INDEX_WIDTH-1:0] pll_phasecounterselect,
  output logic                         pll_phaseupdown,
  output logic                         pll_phasestep,
  output logic                         step_done,
  output logic [$clog2(PLL_STEPS_PER_CYCLE)-1:0] step_phase_pos,
  output logic                         phs_shft_err
);

  localparam int PW   = $clog2(PLL_STEPS_PER_CYCLE);
  localparam int NCLK = 1 << CLOCK_INDEX_WIDTH;
  localparam int M1   = (SETUP_CYCLES > STEP_CYCLES) ?
                        SETUP_CYCLES : STEP_CYCLES;
  localparam int CMAX = (TIMEOUT_CYCLES > M1) ?
                        TIMEOUT_CYCLES : M1;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    INIT, IDLE, SETUP, STEP, WAIT_LO, WAIT_HI, FINISH
  } state_t;

  state_t state_q, state_d;

  logic          lock_m, lock_s;
  logic          done_m, done_s;
  logic          start_q;
  logic          req_edge;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tmo_d;

  logic [CLOCK_INDEX_WIDTH-1:0] sel_q;
  logic [CLOCK_INDEX_WIDTH-1:0] raw_q;
  logic                         dir_q;

  logic [PW-1:0] pos_q [NCLK];
  logic [PW-1:0] pos_cur, pos_nxt;

  assign req_edge = seq_pll_start_reconfig & ~start_q;
  assign pos_cur  = pos_q[raw_q];

  assign pll_phasecounterselect = sel_q;
  assign pll_phaseupdown        = dir_q;

  // Wrapped +/-1 of the latched index's position
  always_comb begin
    pos_nxt = pos_cur;
    if (dir_q) begin
      pos_nxt = (pos_cur == PW'(PLL_STEPS_PER_CYCLE - 1)) ?
                '0 : pos_cur + PW'(1);
    end else begin
      pos_nxt = (pos_cur == '0) ?
                PW'(PLL_STEPS_PER_CYCLE - 1) : pos_cur - PW'(1);
    end
  end

  // Next-state, phase counter and timeout detect
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    tmo_d   = 1'b0;
    unique case (state_q)
      INIT: begin
        cnt_d = '0;
        if (lock_s && done_s) state_d = IDLE;
      end
      IDLE: begin
        cnt_d = '0;
        if (req_edge) state_d = SETUP;
      end
      SETUP: begin
        if (cnt_q == CW'(SETUP_CYCLES - 1)) begin
          state_d = STEP;
          cnt_d   = '0;
        end
      end
      STEP: begin
        if (cnt_q == CW'(STEP_CYCLES - 1)) begin
          state_d = WAIT_LO;
          cnt_d   = '0;
        end
      end
      WAIT_LO: begin
        if (!done_s) begin
          state_d = WAIT_HI;
          cnt_d   = '0;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          state_d = FINISH;
          tmo_d   = 1'b1;
        end
      end
      WAIT_HI: begin
        if (done_s) begin
          state_d = FINISH;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          state_d = FINISH;
          tmo_d   = 1'b1;
        end
      end
      FINISH: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = INIT;
        cnt_d   = '0;
      end
    endcase
    if (!lock_s) begin
      state_d = INIT;
      cnt_d   = '0;
      tmo_d   = 1'b0;
    end
  end

  // Synchronisers, FSM state and registered outputs
  always_ff @(posedge seq_clk) begin
    if (reset_seq) begin
      lock_m         <= 1'b0;
      lock_s         <= 1'b0;
      done_m         <= 1'b0;
      done_s         <= 1'b0;
      start_q        <= 1'b1;
      state_q        <= INIT;
      cnt_q          <= '0;
      sel_q          <= '0;
      raw_q          <= '0;
      dir_q          <= 1'b0;
      phs_shft_busy  <= 1'b1;
      pll_phasestep  <= 1'b0;
      step_done      <= 1'b0;
      step_phase_pos <= '0;
      phs_shft_err   <= 1'b0;
      for (int i = 0; i < NCLK; i++) pos_q[i] <= '0;
    end else begin
      lock_m        <= pll_locked;
      lock_s        <= lock_m;
      done_m        <= pll_phasedone;
      done_s        <= done_m;
      start_q       <= seq_pll_start_reconfig;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      phs_shft_busy <= (state_d != IDLE);
      pll_phasestep <= (state_d == STEP);
      step_done     <= (state_d == FINISH);
      phs_shft_err  <= phs_shft_err | tmo_d;
      if (!lock_s) begin
        sel_q          <= '0;
        raw_q          <= '0;
        dir_q          <= 1'b0;
        step_phase_pos <= '0;
        for (int i = 0; i < NCLK; i++) pos_q[i] <= '0;
      end else begin
        if (state_q == IDLE && req_edge) begin
          sel_q <= seq_pll_select +
                   CLOCK_INDEX_WIDTH'(COUNTER_SELECT_OFFSET);
          raw_q <= seq_pll_select;
          dir_q <= seq_pll_inc_dec_n;
        end
        if (state_d == FINISH) begin
          step_phase_pos <= tmo_d ? pos_cur : pos_nxt;
          if (!tmo_d) pos_q[raw_q] <= pos_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_ddr2_sdram_phy_alt_mem_phy_pll_phase_stepper.sv
// Scoreboard bench for the PLL phase stepper.
// Stimulus queues expectations; a monitor checks each step_done.
module tb_ddr2_sdram_phy_alt_mem_phy_pll_phase_stepper;

  logic       seq_clk = 1'b0;
  logic       reset_seq;
  logic       seq_pll_start_reconfig;
  logic [2:0] seq_pll_select;
  logic       seq_pll_inc_dec_n;
  logic       phs_shft_busy;
  logic       pll_locked;
  logic       pll_phasedone;
  logic [2:0] pll_phasecounterselect;
  logic       pll_phaseupdown;
  logic       pll_phasestep;
  logic       step_done;
  logic [5:0] step_phase_pos;
  logic       phs_shft_err;

  ddr2_sdram_phy_alt_mem_phy_pll_phase_stepper dut (
    .seq_clk                (seq_clk),
    .reset_seq              (reset_seq),
    .seq_pll_start_reconfig (seq_pll_start_reconfig),
    .seq_pll_select         (seq_pll_select),
    .seq_pll_inc_dec_n      (seq_pll_inc_dec_n),
    .phs_shft_busy          (phs_shft_busy),
    .pll_locked             (pll_locked),
    .pll_phasedone          (pll_phasedone),
    .pll_phasecounterselect (pll_phasecounterselect),
    .pll_phaseupdown        (pll_phaseupdown),
    .pll_phasestep          (pll_phasestep),
    .step_done              (step_done),
    .step_phase_pos         (step_phase_pos),
    .phs_shft_err           (phs_shft_err)
  );

  always #5 seq_clk = ~seq_clk;

  typedef struct {
    logic [5:0] pos;
    logic       err;
    logic [2:0] sel;
    logic       dir;
  } exp_t;

  exp_t sb [$];
  int total = 0;
  int bad   = 0;
  int done_cnt  = 0;
  int ps_pulses = 0;
  int ps_w      = 0;
  logic sd_prev = 1'b0;
  int mode = 0;

  task automatic check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // PLL model: mode 0 = 3-cycle low pulse, 1 = stuck high, 2 = stuck low
  initial begin : pll_model
    int lo_cnt;
    bit hold_lo;
    logic ps_d;
    lo_cnt = 0;
    hold_lo = 0;
    ps_d = 1'b0;
    pll_phasedone = 1'b1;
    forever begin
      @(posedge seq_clk);
      #1;
      if (mode != 2) hold_lo = 0;
      if (lo_cnt > 0) begin
        pll_phasedone = 1'b0;
        lo_cnt--;
      end else begin
        pll_phasedone = !hold_lo;
      end
      if (pll_phasestep === 1'b1 && ps_d !== 1'b1) begin
        if (mode == 0) lo_cnt = 3;
        if (mode == 2) hold_lo = 1;
      end
      ps_d = pll_phasestep;
    end
  end

  // Monitor: phasestep width and scoreboard pop on step_done
  always @(negedge seq_clk) begin
    exp_t e;
    if (reset_seq === 1'b0) begin
      if (pll_phasestep === 1'b1) begin
        ps_w++;
      end else if (ps_w > 0) begin
        check("phasestep_width", ps_w, 2);
        ps_pulses++;
        ps_w = 0;
      end
      if (step_done === 1'b1) begin
        done_cnt++;
        check("step_done_1cyc", int'(sd_prev), 0);
        if (sb.size() == 0) begin
          check("sb_has_entry", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          check("pos", int'(step_phase_pos), int'(e.pos));
          check("err", int'(phs_shft_err), int'(e.err));
          check("cntsel", int'(pll_phasecounterselect), int'(e.sel));
          check("updown", int'(pll_phaseupdown), int'(e.dir));
        end
      end
      sd_prev = step_done;
    end
  end

  task automatic wait_idle();
    @(negedge seq_clk);
    for (int i = 0; i < 400 && phs_shft_busy !== 1'b0; i++)
      @(negedge seq_clk);
    check("idle_reached", int'(phs_shft_busy), 0);
  endtask

  task automatic issue(int idx, bit inc, bit spam);
    @(posedge seq_clk);
    #1;
    seq_pll_select = 3'(idx);
    seq_pll_inc_dec_n = inc;
    seq_pll_start_reconfig = 1'b1;
    @(posedge seq_clk);
    #1 seq_pll_start_reconfig = 1'b0;
    if (spam) begin
      repeat (3) @(posedge seq_clk);
      #1 seq_pll_start_reconfig = 1'b1;
      @(posedge seq_clk);
      #1 seq_pll_start_reconfig = 1'b0;
    end
  endtask

  task automatic do_step(int idx, bit inc, int ep, bit ee, bit spam);
    exp_t e;
    int n0;
    wait_idle();
    e.pos = 6'(ep);
    e.err = ee;
    e.sel = 3'(idx + 2);
    e.dir = inc;
    sb.push_back(e);
    n0 = done_cnt;
    issue(idx, inc, spam);
    for (int i = 0; i < 600 && done_cnt == n0; i++)
      @(negedge seq_clk);
    check("step_done_seen", int'(done_cnt != n0), 1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int p0;
    int n0;
    reset_seq = 1'b1;
    seq_pll_start_reconfig = 1'b0;
    seq_pll_select = 3'd0;
    seq_pll_inc_dec_n = 1'b0;
    pll_locked = 1'b0;
    repeat (3) @(posedge seq_clk);
    @(negedge seq_clk);
    check("rst_busy", int'(phs_shft_busy), 1);
    check("rst_step", int'(pll_phasestep), 0);
    check("rst_sel", int'(pll_phasecounterselect), 0);
    check("rst_updown", int'(pll_phaseupdown), 0);
    check("rst_done", int'(step_done), 0);
    check("rst_pos", int'(step_phase_pos), 0);
    check("rst_err", int'(phs_shft_err), 0);
    @(posedge seq_clk);
    #1 reset_seq = 1'b0;
    repeat (3) @(posedge seq_clk);
    @(negedge seq_clk);
    check("init_busy", int'(phs_shft_busy), 1);
    @(posedge seq_clk);
    #1 pll_locked = 1'b1;
    repeat (2) @(posedge seq_clk);
    @(negedge seq_clk);
    check("lock_busy_hold", int'(phs_shft_busy), 1);
    @(negedge seq_clk);
    check("lock_busy_fall", int'(phs_shft_busy), 0);

    do_step(1, 1'b1, 1, 1'b0, 1'b0);

    do_step(0, 1'b0, 63, 1'b0, 1'b0);
    for (int i = 0; i < 64; i++)
      do_step(0, 1'b1, i, 1'b0, 1'b0);

    mode = 1;
    do_step(0, 1'b1, 63, 1'b1, 1'b0);
    mode = 0;
    do_step(0, 1'b1, 0, 1'b1, 1'b0);

    wait_idle();
    p0 = ps_pulses;
    do_step(2, 1'b0, 63, 1'b1, 1'b1);
    repeat (6) @(negedge seq_clk);
    check("ignored_pulses", ps_pulses - p0, 1);
    check("ignored_busy", int'(phs_shft_busy), 0);

    wait_idle();
    mode = 2;
    n0 = done_cnt;
    issue(3, 1'b1, 1'b0);
    repeat (12) @(negedge seq_clk);
    check("wait_hi_busy", int'(phs_shft_busy), 1);
    @(posedge seq_clk);
    #1 pll_locked = 1'b0;
    repeat (4) @(negedge seq_clk);
    check("loss_busy", int'(phs_shft_busy), 1);
    check("loss_step", int'(pll_phasestep), 0);
    check("loss_no_done", done_cnt - n0, 0);
    check("loss_err_kept", int'(phs_shft_err), 1);
    mode = 0;
    @(posedge seq_clk);
    #1 pll_locked = 1'b1;
    do_step(1, 1'b1, 1, 1'b1, 1'b0);
    do_step(2, 1'b1, 1, 1'b1, 1'b0);

    repeat (5) @(negedge seq_clk);
    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
